// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap and interrupt controller.
// Converts committed exceptions, mret and synchronized interrupt lines into
// CSR hardware-write strobes, drains the pipeline before taking an interrupt,
// and issues a single redirect to fetch over a valid/ready handshake.
// Optional feature macro: TRAP_VECTORED_EN (mtvec mode 1 vectors interrupts
// to base*4 + 4*cause; when undefined every trap goes to base*4).
module trap_ctrl #(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exc_valid,
  input  logic [3:0]        exc_code,
  input  logic [XLEN-1:0]   exc_pc,
  input  logic [XLEN-1:0]   exc_tval,
  input  logic              mret_valid,
  input  logic [XLEN-1:0]   next_pc,
  input  logic              pipe_empty,
  input  logic              irq_software,
  input  logic              irq_timer,
  input  logic              irq_external,
  input  logic              csr_rd_mstatus_mie,
  input  logic              csr_rd_mstatus_mpie,
  input  logic              csr_rd_mie_msie,
  input  logic              csr_rd_mie_mtie,
  input  logic              csr_rd_mie_meie,
  input  logic [XLEN-3:0]   csr_rd_mtvec_base,
  input  logic [1:0]        csr_rd_mtvec_mode,
  input  logic [XLEN-1:0]   csr_rd_mepc,
  output logic              trap,
  output logic              csr_mstatus_wen,
  output logic              csr_wr_mstatus_mie,
  output logic              csr_wr_mstatus_mpie,
  output logic [XLEN-1:0]   csr_wr_mepc_mepc,
  output logic [XLEN-1:0]   csr_wr_mtval_mtval,
  output logic [XLEN-2:0]   csr_wr_mcause_exception_code,
  output logic              csr_wr_mcause_interrupt,
  output logic              csr_set_mip_msip,
  output logic              csr_set_mip_mtip,
  output logic              csr_set_mip_meip,
  output logic              hold_issue,
  output logic              flush,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  input  logic              redirect_ready
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_TRAP     = 3'd2,
    ST_MRET     = 3'd3,
    ST_REDIRECT = 3'd4
  } state_t;

  localparam logic [XLEN-2:0] CAUSE_MSI = {{(XLEN-5){1'b0}}, 4'd3};
  localparam logic [XLEN-2:0] CAUSE_MTI = {{(XLEN-5){1'b0}}, 4'd7};
  localparam logic [XLEN-2:0] CAUSE_MEI = {{(XLEN-5){1'b0}}, 4'd11};

  // Interrupt cause arbitration: external beats software beats timer.
  function automatic logic [XLEN-2:0] irq_cause(input logic me, input logic ms);
    logic [XLEN-2:0] c;
    if (me) begin
      c = CAUSE_MEI;
    end else if (ms) begin
      c = CAUSE_MSI;
    end else begin
      c = CAUSE_MTI;
    end
    return c;
  endfunction

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] sw_sync_r;
  logic [SYNC_STAGES-1:0] tmr_sync_r;
  logic [SYNC_STAGES-1:0] ext_sync_r;

  logic            ms_s;
  logic            mt_s;
  logic            me_s;
  logic            irq_take_s;
  logic [XLEN-2:0] irq_code_s;
  logic            go_exc_s;
  logic            go_mret_s;
  logic            go_drain_s;
  logic            go_irq_trap_s;
  logic            drop_s;
  logic            vec_en_s;
  logic [XLEN-1:0] trap_target_s;
  logic            unused_s;

  // Interrupt synchronizer chains; the last stage is the visible level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_sync_r  <= {SYNC_STAGES{1'b0}};
      tmr_sync_r <= {SYNC_STAGES{1'b0}};
      ext_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sw_sync_r  <= {sw_sync_r[SYNC_STAGES-2:0], irq_software};
      tmr_sync_r <= {tmr_sync_r[SYNC_STAGES-2:0], irq_timer};
      ext_sync_r <= {ext_sync_r[SYNC_STAGES-2:0], irq_external};
    end
  end

  assign csr_set_mip_msip = sw_sync_r[SYNC_STAGES-1];
  assign csr_set_mip_mtip = tmr_sync_r[SYNC_STAGES-1];
  assign csr_set_mip_meip = ext_sync_r[SYNC_STAGES-1];

  assign ms_s       = sw_sync_r[SYNC_STAGES-1] & csr_rd_mie_msie;
  assign mt_s       = tmr_sync_r[SYNC_STAGES-1] & csr_rd_mie_mtie;
  assign me_s       = ext_sync_r[SYNC_STAGES-1] & csr_rd_mie_meie;
  assign irq_take_s = csr_rd_mstatus_mie & (ms_s | mt_s | me_s);
  assign irq_code_s = irq_cause(me_s, ms_s);

`ifdef TRAP_VECTORED_EN
  // Only interrupts are vectored; exceptions always land on the base.
  assign vec_en_s = (csr_rd_mtvec_mode == 2'd1) & csr_wr_mcause_interrupt;
  assign unused_s = ^exc_pc[1:0];
`else
  assign vec_en_s = 1'b0;
  assign unused_s = ^{exc_pc[1:0], csr_rd_mtvec_mode};
`endif

  // Trap target from mtvec, using the cause latched on trap entry.
  always_comb begin
    trap_target_s = {csr_rd_mtvec_base, 2'b00};
    if (vec_en_s) begin
      trap_target_s = {csr_rd_mtvec_base, 2'b00} +
                      {csr_wr_mcause_exception_code[XLEN-3:0], 2'b00};
    end else begin
      trap_target_s = {csr_rd_mtvec_base, 2'b00};
    end
  end

  // Decision decode for IDLE and DRAIN: exception > mret > interrupt.
  always_comb begin
    go_exc_s      = 1'b0;
    go_mret_s     = 1'b0;
    go_drain_s    = 1'b0;
    go_irq_trap_s = 1'b0;
    drop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (exc_valid) begin
          go_exc_s = 1'b1;
        end else if (mret_valid) begin
          go_mret_s = 1'b1;
        end else if (irq_take_s) begin
          go_drain_s = 1'b1;
        end else begin
          go_drain_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (exc_valid) begin
          go_exc_s = 1'b1;
        end else if (mret_valid) begin
          go_mret_s = 1'b1;
        end else if (!irq_take_s) begin
          drop_s = 1'b1;
        end else if (pipe_empty) begin
          go_irq_trap_s = 1'b1;
        end else begin
          drop_s = 1'b0;
        end
      end
      default: begin
        go_exc_s = 1'b0;
      end
    endcase
  end

  // Control FSM with registered strobes, CSR write values and redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r                      <= ST_IDLE;
      trap                         <= 1'b0;
      csr_mstatus_wen              <= 1'b0;
      csr_wr_mstatus_mie           <= 1'b0;
      csr_wr_mstatus_mpie          <= 1'b0;
      csr_wr_mepc_mepc             <= {XLEN{1'b0}};
      csr_wr_mtval_mtval           <= {XLEN{1'b0}};
      csr_wr_mcause_exception_code <= {(XLEN-1){1'b0}};
      csr_wr_mcause_interrupt      <= 1'b0;
      hold_issue                   <= 1'b0;
      flush                        <= 1'b0;
      redirect_valid               <= 1'b0;
      redirect_pc                  <= {XLEN{1'b0}};
    end else begin
      // Strobes are single-cycle unless re-armed below.
      trap            <= 1'b0;
      csr_mstatus_wen <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DRAIN: begin
          if (go_exc_s) begin
            state_r                      <= ST_TRAP;
            trap                         <= 1'b1;
            flush                        <= 1'b1;
            hold_issue                   <= 1'b0;
            csr_wr_mcause_exception_code <= {{(XLEN-5){1'b0}}, exc_code};
            csr_wr_mcause_interrupt      <= 1'b0;
            csr_wr_mepc_mepc             <= {exc_pc[XLEN-1:2], 2'b00};
            csr_wr_mtval_mtval           <= exc_tval;
            csr_wr_mstatus_mie           <= 1'b0;
            csr_wr_mstatus_mpie          <= csr_rd_mstatus_mie;
          end else if (go_mret_s) begin
            state_r             <= ST_MRET;
            csr_mstatus_wen     <= 1'b1;
            flush               <= 1'b1;
            hold_issue          <= 1'b0;
            csr_wr_mstatus_mie  <= csr_rd_mstatus_mpie;
            csr_wr_mstatus_mpie <= 1'b1;
          end else if (go_irq_trap_s) begin
            state_r                      <= ST_TRAP;
            trap                         <= 1'b1;
            flush                        <= 1'b1;
            hold_issue                   <= 1'b0;
            csr_wr_mcause_exception_code <= irq_code_s;
            csr_wr_mcause_interrupt      <= 1'b1;
            csr_wr_mepc_mepc             <= next_pc;
            csr_wr_mtval_mtval           <= {XLEN{1'b0}};
            csr_wr_mstatus_mie           <= 1'b0;
            csr_wr_mstatus_mpie          <= csr_rd_mstatus_mie;
          end else if (go_drain_s) begin
            state_r    <= ST_DRAIN;
            hold_issue <= 1'b1;
          end else if (drop_s) begin
            state_r    <= ST_IDLE;
            hold_issue <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_TRAP: begin
          state_r        <= ST_REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_target_s;
          flush          <= 1'b1;
          hold_issue     <= 1'b1;
        end
        ST_MRET: begin
          state_r        <= ST_REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= csr_rd_mepc;
          flush          <= 1'b1;
          hold_issue     <= 1'b1;
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            state_r        <= ST_IDLE;
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            hold_issue     <= 1'b0;
          end else begin
            state_r <= ST_REDIRECT;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
          hold_issue     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes expected CSR writes and
// redirects; a monitor pops and compares whenever the DUT emits one.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc, exc_tval, next_pc, csr_rd_mepc;
  logic        mret_valid, pipe_empty;
  logic        irq_software, irq_timer, irq_external;
  logic        csr_rd_mstatus_mie, csr_rd_mstatus_mpie;
  logic        csr_rd_mie_msie, csr_rd_mie_mtie, csr_rd_mie_meie;
  logic [29:0] csr_rd_mtvec_base;
  logic [1:0]  csr_rd_mtvec_mode;
  logic        trap, csr_mstatus_wen, csr_wr_mstatus_mie, csr_wr_mstatus_mpie;
  logic [31:0] csr_wr_mepc_mepc, csr_wr_mtval_mtval;
  logic [30:0] csr_wr_mcause_exception_code;
  logic        csr_wr_mcause_interrupt;
  logic        csr_set_mip_msip, csr_set_mip_mtip, csr_set_mip_meip;
  logic        hold_issue, flush, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;

  trap_ctrl dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .next_pc(next_pc), .pipe_empty(pipe_empty),
    .irq_software(irq_software), .irq_timer(irq_timer), .irq_external(irq_external),
    .csr_rd_mstatus_mie(csr_rd_mstatus_mie), .csr_rd_mstatus_mpie(csr_rd_mstatus_mpie),
    .csr_rd_mie_msie(csr_rd_mie_msie), .csr_rd_mie_mtie(csr_rd_mie_mtie),
    .csr_rd_mie_meie(csr_rd_mie_meie),
    .csr_rd_mtvec_base(csr_rd_mtvec_base), .csr_rd_mtvec_mode(csr_rd_mtvec_mode),
    .csr_rd_mepc(csr_rd_mepc),
    .trap(trap), .csr_mstatus_wen(csr_mstatus_wen),
    .csr_wr_mstatus_mie(csr_wr_mstatus_mie), .csr_wr_mstatus_mpie(csr_wr_mstatus_mpie),
    .csr_wr_mepc_mepc(csr_wr_mepc_mepc), .csr_wr_mtval_mtval(csr_wr_mtval_mtval),
    .csr_wr_mcause_exception_code(csr_wr_mcause_exception_code),
    .csr_wr_mcause_interrupt(csr_wr_mcause_interrupt),
    .csr_set_mip_msip(csr_set_mip_msip), .csr_set_mip_mtip(csr_set_mip_mtip),
    .csr_set_mip_meip(csr_set_mip_meip),
    .hold_issue(hold_issue), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  // kind: 0 = trap write, 1 = mret mstatus write, 2 = redirect handshake
  typedef struct {
    int          kind;
    logic [31:0] mepc;
    logic [31:0] mtval;
    logic [31:0] mcause;
    logic        mie;
    logic        mpie;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_pc = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic push_trap(input logic [31:0] mepc, input logic [31:0] mtval,
                           input logic [31:0] mcause, input logic mpie);
    exp_t e;
    e.kind = 0; e.mepc = mepc; e.mtval = mtval; e.mcause = mcause;
    e.mie = 1'b0; e.mpie = mpie; e.pc = 32'd0;
    sb.push_back(e);
  endtask

  task automatic push_mret(input logic mie, input logic mpie);
    exp_t e;
    e.kind = 1; e.mepc = 32'd0; e.mtval = 32'd0; e.mcause = 32'd0;
    e.mie = mie; e.mpie = mpie; e.pc = 32'd0;
    sb.push_back(e);
  endtask

  task automatic push_redir(input logic [31:0] pc);
    exp_t e;
    e.kind = 2; e.mepc = 32'd0; e.mtval = 32'd0; e.mcause = 32'd0;
    e.mie = 1'b0; e.mpie = 1'b0; e.pc = pc;
    sb.push_back(e);
  endtask

  // Monitor: pop on every DUT event and compare against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   ev;
    if (rst) begin
      prev_wait = 1'b0;
    end else begin
      if (trap && csr_mstatus_wen) chk("trap_wen_exclusive", 32'd1, 32'd0);
      if (prev_wait && redirect_valid) chk("redirect_pc_stable", redirect_pc, prev_pc);
      prev_wait = redirect_valid && !redirect_ready;
      prev_pc   = redirect_pc;
      if (trap || csr_mstatus_wen || (redirect_valid && redirect_ready)) begin
        ev = trap ? 0 : (csr_mstatus_wen ? 1 : 2);
        if (sb.size() == 0) begin
          chk("unexpected_event", ev + 1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("event_kind", ev, e.kind);
          if (e.kind == 0) begin
            chk("mepc", csr_wr_mepc_mepc, e.mepc);
            chk("mtval", csr_wr_mtval_mtval, e.mtval);
            chk("mcause", {csr_wr_mcause_interrupt, csr_wr_mcause_exception_code}, e.mcause);
            chk("trap_mie", {31'd0, csr_wr_mstatus_mie}, {31'd0, e.mie});
            chk("trap_mpie", {31'd0, csr_wr_mstatus_mpie}, {31'd0, e.mpie});
          end else if (e.kind == 1) begin
            chk("mret_mie", {31'd0, csr_wr_mstatus_mie}, {31'd0, e.mie});
            chk("mret_mpie", {31'd0, csr_wr_mstatus_mpie}, {31'd0, e.mpie});
          end else begin
            chk("redirect_pc", redirect_pc, e.pc);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One-cycle exception; afterwards trap must be high (latency 1).
  task automatic do_exc(input logic [3:0] code, input logic [31:0] pc, input logic [31:0] tval);
    tick();
    exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_tval = tval;
    tick();
    exc_valid = 1'b0;
    chk("exc_trap_latency", {31'd0, trap}, 32'd1);
  endtask

  task automatic wait_hold(input string name);
    int n = 0;
    while (!hold_issue && n < 12) begin tick(); n++; end
    chk(name, {31'd0, hold_issue}, 32'd1);
  endtask

  task automatic wait_trap(input string name);
    int n = 0;
    while (!trap && n < 12) begin tick(); n++; end
    chk(name, {31'd0, trap}, 32'd1);
  endtask

  // Wait for redirect, keep ready low for hold cycles, then accept it.
  task automatic finish_redirect(input int hold);
    int n = 0;
    while (!redirect_valid && n < 12) begin tick(); n++; end
    chk("redirect_seen", {31'd0, redirect_valid}, 32'd1);
    repeat (hold) tick();
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("redirect_released", {31'd0, redirect_valid}, 32'd0);
    chk("hold_released", {31'd0, hold_issue}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; exc_valid = 1'b0; exc_code = 4'd0; exc_pc = 32'd0; exc_tval = 32'd0;
    mret_valid = 1'b0; next_pc = 32'd0; pipe_empty = 1'b0;
    irq_software = 1'b0; irq_timer = 1'b0; irq_external = 1'b0;
    csr_rd_mstatus_mie = 1'b1; csr_rd_mstatus_mpie = 1'b0;
    csr_rd_mie_msie = 1'b0; csr_rd_mie_mtie = 1'b0; csr_rd_mie_meie = 1'b0;
    csr_rd_mtvec_base = 30'h40; csr_rd_mtvec_mode = 2'd0; csr_rd_mepc = 32'd0;
    redirect_ready = 1'b0;
    repeat (3) tick();
    // Reset state
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_hold", {31'd0, hold_issue}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_mepc", csr_wr_mepc_mepc, 32'd0);
    chk("rst_mip", {29'd0, csr_set_mip_msip, csr_set_mip_mtip, csr_set_mip_meip}, 32'd0);
    rst = 1'b0;
    tick();

    // Exception, mtvec 0x100, redirect held through 3 not-ready cycles
    push_trap(32'h1004, 32'hDEAD, 32'h0000_0002, 1'b1);
    push_redir(32'h100);
    do_exc(4'd2, 32'h1006, 32'hDEAD);
    chk("exc_flush", {31'd0, flush}, 32'd1);
    finish_redirect(3);

    // Vectored timer interrupt, mtvec 0x201, pipe empties 4 cycles into DRAIN
    csr_rd_mie_mtie = 1'b1; csr_rd_mtvec_base = 30'h80; csr_rd_mtvec_mode = 2'd1;
    next_pc = 32'h40; irq_timer = 1'b1;
    push_trap(32'h40, 32'h0, 32'h8000_0007, 1'b1);
`ifdef TRAP_VECTORED_EN
    push_redir(32'h21C);
`else
    push_redir(32'h200);
`endif
    tick();
    chk("mtip_sync_1", {31'd0, csr_set_mip_mtip}, 32'd0);
    tick();
    chk("mtip_sync_2", {31'd0, csr_set_mip_mtip}, 32'd1);
    wait_hold("tmr_drain_entry");
    chk("tmr_no_early_trap", {31'd0, trap}, 32'd0);
    repeat (4) tick();
    pipe_empty = 1'b1;
    tick();
    chk("tmr_trap_after_empty", {31'd0, trap}, 32'd1);
    irq_timer = 1'b0; csr_rd_mie_mtie = 1'b0; pipe_empty = 1'b0;
    finish_redirect(1);

    // Priority: external over software, direct mtvec 0x100
    csr_rd_mtvec_base = 30'h40; csr_rd_mtvec_mode = 2'd0;
    csr_rd_mie_msie = 1'b1; csr_rd_mie_meie = 1'b1;
    irq_software = 1'b1; irq_external = 1'b1; pipe_empty = 1'b1; next_pc = 32'h80;
    push_trap(32'h80, 32'h0, 32'h8000_000B, 1'b1);
    push_redir(32'h100);
    wait_trap("prio_trap_seen");
    irq_software = 1'b0; irq_external = 1'b0; pipe_empty = 1'b0;
    csr_rd_mie_msie = 1'b0; csr_rd_mie_meie = 1'b0;
    finish_redirect(0);

    // Exception during DRAIN preempts the interrupt; exceptions never vector
    csr_rd_mtvec_base = 30'h80; csr_rd_mtvec_mode = 2'd1;
    csr_rd_mie_mtie = 1'b1; irq_timer = 1'b1;
    wait_hold("preempt_drain_entry");
    push_trap(32'h2000, 32'h11, 32'h0000_0005, 1'b1);
    push_redir(32'h200);
    do_exc(4'd5, 32'h2002, 32'h11);
    irq_timer = 1'b0; csr_rd_mie_mtie = 1'b0;
    finish_redirect(2);

    // mret: mpie=1, mepc 0x3000
    csr_rd_mstatus_mie = 1'b0; csr_rd_mstatus_mpie = 1'b1; csr_rd_mepc = 32'h3000;
    push_mret(1'b1, 1'b1);
    push_redir(32'h3000);
    tick();
    mret_valid = 1'b1;
    tick();
    mret_valid = 1'b0;
    chk("mret_wen_latency", {31'd0, csr_mstatus_wen}, 32'd1);
    chk("mret_no_trap", {31'd0, trap}, 32'd0);
    finish_redirect(1);
    csr_rd_mstatus_mie = 1'b1; csr_rd_mstatus_mpie = 1'b0;

    // Abort: timer drops during DRAIN, back to IDLE without a trap
    csr_rd_mie_mtie = 1'b1; irq_timer = 1'b1;
    wait_hold("abort_drain_entry");
    tick();
    irq_timer = 1'b0;
    repeat (4) tick();
    chk("abort_hold_drop", {31'd0, hold_issue}, 32'd0);
    chk("abort_no_flush", {31'd0, flush}, 32'd0);
    csr_rd_mie_mtie = 1'b0;

    // Reset while in REDIRECT
    push_trap(32'h500, 32'h0, 32'h0000_000B, 1'b1);
    do_exc(4'd11, 32'h500, 32'h0);
    tick();
    chk("rst_pre_redirect", {31'd0, redirect_valid}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_mid_trap", {31'd0, trap}, 32'd0);
    chk("rst_mid_hold", {31'd0, hold_issue}, 32'd0);
    chk("rst_mid_flush", {31'd0, flush}, 32'd0);
    chk("rst_mid_mepc", csr_wr_mepc_mepc, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_after_redirect_valid", {31'd0, redirect_valid}, 32'd0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
